rggen_multi_bus_exporter: RTL and testbench
===========================================

Name: rggen_multi_bus_exporter

Overview:
- Parametrised successor of the single-window bus exporter.
- Forwards one register-block access to one of CHANNELS external bus windows.
- Registers the external request and registers the external response back to the local bus.
- Optional watchdog terminates hung external accesses with an error status.
- Sits between the register block's local bus decoder and external sub-blocks mapped into its address space.

Parameters:
DATA_WIDTH, 32, data width in bits (multiple of 8)
LOCAL_ADDRESS_WIDTH, 16, local address width
EXTERNAL_ADDRESS_WIDTH, 8, external address width, shared by all channels
CHANNELS, 2, number of external windows (>=1)
START_ADDRESS, {CHANNELS{16'h0000}}, packed CHANNELS*LOCAL_ADDRESS_WIDTH; slice n is window n base
TIMEOUT_CYCLES, 256, watchdog limit in cycles (>=2); used only with the optional feature

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
i_valid  input  1  local access valid
i_select  input  CHANNELS  window hit per channel
i_write  input  1  write access
i_read  input  1  read access
i_address  input  LOCAL_ADDRESS_WIDTH  local address
i_strobe  input  DATA_WIDTH/8  byte strobe
i_write_data  input  DATA_WIDTH  write data
o_ready  output  1  local response valid (one-cycle pulse)
o_read_data  output  DATA_WIDTH  local read data
o_status  output  2  local status: 00 OKAY, 10 SLVERR
o_valid  output  CHANNELS  external request valid, one-hot
o_write  output  1  external write
o_read  output  1  external read
o_address  output  EXTERNAL_ADDRESS_WIDTH  external address
o_strobe  output  DATA_WIDTH/8  external strobe
o_write_data  output  DATA_WIDTH  external write data
i_ready  input  CHANNELS  external ready per channel
i_read_data  input  CHANNELS*DATA_WIDTH  external read data, slice n = channel n
i_status  input  CHANNELS*2  external status, slice n = channel n

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All flops are cleared when rst=1 at a clk edge.
- Reset values: all outputs 0; state IDLE.
- FSM states:
  - IDLE: if i_valid && |i_select:
    - Latch channel index = lowest set bit of i_select.
    - Latch write, read, strobe and write_data.
    - Latch address = (i_address - START_ADDRESS[ch]) modulo 2^LOCAL_ADDRESS_WIDTH, truncated to the low EXTERNAL_ADDRESS_WIDTH bits.
    - Go to REQUEST.
    - If i_select == 0, stay in IDLE.
  - REQUEST:
    - o_valid[ch]=1; all other o_valid bits 0. Request fields are held stable.
    - On i_ready[ch]: capture i_read_data slice ch and i_status slice ch; clear o_valid and all request fields to 0; go to RESPOND. i_ready of non-selected channels is ignored.
  - RESPOND: o_ready=1 for exactly one cycle, with the captured data/status; go to DONE.
  - DONE: one guard cycle, i_valid ignored; go to IDLE. This prevents re-issue while upstream drops i_valid.
- Latency: o_valid rises 1 cycle after acceptance; o_ready rises 1 cycle after i_ready[ch]. Minimum access = 3 cycles; back-to-back issue every 4 cycles.
- o_read_data/o_status are 0 whenever o_ready=0.
- i_valid deasserting during REQUEST does not abort the access: the external access completes and the RESPOND pulse still occurs.
- i_select with multiple bits set: lowest index wins; the other bits are ignored.
- Address wrap: a local address below the window base wraps modulo 2^LOCAL_ADDRESS_WIDTH before truncation.
- Reset in any state: return to IDLE next edge; o_valid drops immediately at that edge; no o_ready pulse.

Optional Feature:
RGGEN_BUS_EXPORTER_TIMEOUT_EN
- Defined:
  - A counter clears on entering REQUEST and increments each REQUEST cycle without i_ready[ch].
  - When the count reaches TIMEOUT_CYCLES-1 with no ready: drop o_valid, capture read data 0 and status 2'b10, go to RESPOND.
  - If i_ready[ch] arrives in the same cycle as the limit, ready wins and the real response is returned.
- Undefined: no counter; REQUEST waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package rggen_bus_exporter_pkg:
  - State enum: IDLE, REQUEST, RESPOND, DONE.
  - Status constants: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
  - Function: lowest-set-bit index.
- Sub-module rggen_bus_exporter_timer: load/count/expire counter, instantiated only under the macro.

Test Plan:
- CHANNELS=2, START_ADDRESS={16'h0100,16'h0040}; write to 16'h0044, select=01, strobe=4'hF, wdata 32'hCAFE0001; ready after 2 cycles -> o_valid=01, o_address=8'h04, o_write=1; o_ready pulse 1 cycle after ready, status 00.
- Read to 16'h0108, select=10; i_read_data slice1=32'h12345678, i_status=00 -> o_address=8'h08, o_valid=10; o_read_data=32'h12345678.
- select=11 -> only channel 0 driven; i_ready[1] asserted alone -> ignored, FSM stays in REQUEST.
- Macro defined, TIMEOUT_CYCLES=4, ready never asserted -> o_valid high exactly 4 cycles; then o_ready with data 0, status 10. Ready on the 4th cycle -> real response returned.
- rst=1 during REQUEST -> next edge: all outputs 0, FSM in IDLE; held i_valid is re-accepted after rst=0.
- i_valid held high through DONE -> exactly one external access per 4-cycle period, never a duplicate issue in DONE.

Source files
------------

// File: rtl/rggen_bus_exporter_pkg.sv
// Shared types, status codes and helpers for the multi-window bus exporter.
package rggen_bus_exporter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RESPOND = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY = 2'b01;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    // Upper bound on CHANNELS; the select vector is zero-extended to this width.
    localparam int MAX_CHANNELS = 32;

    function automatic int lowest_set_bit(input logic [MAX_CHANNELS-1:0] vec);
        lowest_set_bit = 0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_bit = i;
            end
        end
    endfunction

endpackage

// File: rtl/rggen_bus_exporter_timer.sv
// Watchdog counter for a pending external request: load clears, count advances,
// expire flags the last permitted cycle.
module rggen_bus_exporter_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rggen_multi_bus_exporter.sv
// Forwards one local register access to one of CHANNELS external windows with
// registered request and response. Watchdog enabled by RGGEN_BUS_EXPORTER_TIMEOUT_EN.
module rggen_multi_bus_exporter
    import rggen_bus_exporter_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int LOCAL_ADDRESS_WIDTH    = 16,
    parameter int EXTERNAL_ADDRESS_WIDTH = 8,
    parameter int CHANNELS               = 2,
    parameter logic [CHANNELS*LOCAL_ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter int TIMEOUT_CYCLES         = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    input  logic [CHANNELS-1:0]                i_select,
    input  logic                               i_write,
    input  logic                               i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]     i_address,
    input  logic [DATA_WIDTH/8-1:0]            i_strobe,
    input  logic [DATA_WIDTH-1:0]              i_write_data,
    output logic                               o_ready,
    output logic [DATA_WIDTH-1:0]              o_read_data,
    output logic [1:0]                         o_status,
    output logic [CHANNELS-1:0]                o_valid,
    output logic                               o_write,
    output logic                               o_read,
    output logic [EXTERNAL_ADDRESS_WIDTH-1:0]  o_address,
    output logic [DATA_WIDTH/8-1:0]            o_strobe,
    output logic [DATA_WIDTH-1:0]              o_write_data,
    input  logic [CHANNELS-1:0]                i_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     i_read_data,
    input  logic [CHANNELS*2-1:0]              i_status
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                            state_q, state_d;
    logic [CH_W-1:0]                   ch_q, ch_d;
    logic [CHANNELS-1:0]               valid_q, valid_d;
    logic                              write_q, write_d;
    logic                              read_q, read_d;
    logic [EXTERNAL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [STRB_W-1:0]                 strb_q, strb_d;
    logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
    logic                              rsp_ready_q, rsp_ready_d;
    logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;
    logic [1:0]                        status_q, status_d;

    logic                              accept;
    logic                              ext_ready;
    logic                              timeout_expire;
    logic [CH_W-1:0]                   sel_ch;
    logic [LOCAL_ADDRESS_WIDTH-1:0]    sel_base;

    assign sel_ch    = CH_W'(lowest_set_bit(MAX_CHANNELS'(i_select)));
    assign sel_base  = START_ADDRESS[int'(sel_ch)*LOCAL_ADDRESS_WIDTH +: LOCAL_ADDRESS_WIDTH];
    assign accept    = (state_q == IDLE) && i_valid && (|i_select);
    assign ext_ready = i_ready[ch_q];

`ifdef RGGEN_BUS_EXPORTER_TIMEOUT_EN
    logic timer_expire;

    rggen_bus_exporter_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .count_i  ((state_q == REQUEST) && !ext_ready),
        .expire_o (timer_expire)
    );

    assign timeout_expire = (state_q == REQUEST) && timer_expire;
`else
    assign timeout_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        valid_d     = valid_q;
        write_d     = write_q;
        read_d      = read_q;
        addr_d      = addr_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        rsp_ready_d = rsp_ready_q;
        rdata_d     = rdata_q;
        status_d    = status_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQUEST;
                    ch_d    = sel_ch;
                    valid_d = CHANNELS'(1) << sel_ch;
                    write_d = i_write;
                    read_d  = i_read;
                    // Window offset wraps modulo the local space before truncation.
                    addr_d  = EXTERNAL_ADDRESS_WIDTH'(i_address - sel_base);
                    strb_d  = i_strobe;
                    wdata_d = i_write_data;
                end
            end
            REQUEST: begin
                if (ext_ready || timeout_expire) begin
                    state_d     = RESPOND;
                    valid_d     = '0;
                    write_d     = 1'b0;
                    read_d      = 1'b0;
                    addr_d      = '0;
                    strb_d      = '0;
                    wdata_d     = '0;
                    rsp_ready_d = 1'b1;
                    if (ext_ready) begin
                        rdata_d  = i_read_data[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
                        status_d = i_status[int'(ch_q)*2 +: 2];
                    end else begin
                        rdata_d  = '0;
                        status_d = STATUS_SLVERR;
                    end
                end
            end
            RESPOND: begin
                state_d     = DONE;
                rsp_ready_d = 1'b0;
                rdata_d     = '0;
                status_d    = STATUS_OKAY;
            end
            default: begin
                // Guard cycle so a still-high i_valid is not issued twice.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            valid_q     <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            strb_q      <= '0;
            wdata_q     <= '0;
            rsp_ready_q <= 1'b0;
            rdata_q     <= '0;
            status_q    <= STATUS_OKAY;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            write_q     <= write_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            rsp_ready_q <= rsp_ready_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_write      = write_q;
    assign o_read       = read_q;
    assign o_address    = addr_q;
    assign o_strobe     = strb_q;
    assign o_write_data = wdata_q;
    assign o_ready      = rsp_ready_q;
    assign o_read_data  = rdata_q;
    assign o_status     = status_q;

endmodule

// File: tb/tb_rggen_multi_bus_exporter.sv
// Scoreboard bench for rggen_multi_bus_exporter; timeout vectors run when
// RGGEN_BUS_EXPORTER_TIMEOUT_EN is defined.
module tb_rggen_multi_bus_exporter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [1:0]  i_select;
    logic        i_write;
    logic        i_read;
    logic [15:0] i_address;
    logic [3:0]  i_strobe;
    logic [31:0] i_write_data;
    logic        o_ready;
    logic [31:0] o_read_data;
    logic [1:0]  o_status;
    logic [1:0]  o_valid;
    logic        o_write;
    logic        o_read;
    logic [7:0]  o_address;
    logic [3:0]  o_strobe;
    logic [31:0] o_write_data;
    logic [1:0]  i_ready;
    logic [63:0] i_read_data;
    logic [3:0]  i_status;

    rggen_multi_bus_exporter #(
        .DATA_WIDTH             (32),
        .LOCAL_ADDRESS_WIDTH    (16),
        .EXTERNAL_ADDRESS_WIDTH (8),
        .CHANNELS               (2),
        .START_ADDRESS          ({16'h0100, 16'h0040}),
        .TIMEOUT_CYCLES         (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_select     (i_select),
        .i_write      (i_write),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_strobe     (i_strobe),
        .i_write_data (i_write_data),
        .o_ready      (o_ready),
        .o_read_data  (o_read_data),
        .o_status     (o_status),
        .o_valid      (o_valid),
        .o_write      (o_write),
        .o_read       (o_read),
        .o_address    (o_address),
        .o_strobe     (o_strobe),
        .o_write_data (o_write_data),
        .i_ready      (i_ready),
        .i_read_data  (i_read_data),
        .i_status     (i_status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;

    // {valid, write, read, address, strobe, write_data}
    logic [47:0] req_q[$];
    // {read_data, status}
    logic [33:0] rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a request or response.
    logic [47:0] cur_req;
    logic [47:0] prev_req = '0;
    logic [1:0]  prev_valid = '0;
    logic [47:0] exp_req;
    logic [33:0] exp_rsp;

    always @(negedge clk) begin
        if (mon_en) begin
            cur_req = {o_valid, o_write, o_read, o_address, o_strobe, o_write_data};
            if (o_valid != 2'b00) begin
                if (prev_valid == 2'b00) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 64'(cur_req), 64'(0));
                    end else begin
                        exp_req = req_q.pop_front();
                        check("req_fields", 64'(cur_req), 64'(exp_req));
                    end
                end else begin
                    check("req_stable", 64'(cur_req), 64'(prev_req));
                end
            end else begin
                check("req_idle_zero", 64'(cur_req), 64'(0));
            end
            prev_valid = o_valid;
            prev_req   = cur_req;
            if (o_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({o_read_data, o_status}), 64'(0));
                    n_errors += (o_read_data == 0 && o_status == 0) ? 1 : 0;
                end else begin
                    exp_rsp = rsp_q.pop_front();
                    check("rsp_fields", 64'({o_read_data, o_status}), 64'(exp_rsp));
                end
            end else begin
                check("rsp_idle_zero", 64'({o_read_data, o_status}), 64'(0));
            end
        end
    end

    task automatic clear_inputs();
        i_valid      = 1'b0;
        i_select     = 2'b00;
        i_write      = 1'b0;
        i_read       = 1'b0;
        i_address    = 16'h0000;
        i_strobe     = 4'h0;
        i_write_data = 32'h0;
    endtask

    task automatic drive_ready(input logic [1:0] ch_vec, input logic [31:0] rdata, input logic [1:0] st);
        i_ready = ch_vec;
        if (ch_vec[0]) begin
            i_read_data = {32'hDEAD_BEEF, rdata};
            i_status    = {~st, st};
        end else begin
            i_read_data = {rdata, 32'hDEAD_BEEF};
            i_status    = {st, ~st};
        end
    endtask

    // Called at posedge+1 with the FSM idle; returns at posedge+1 with the FSM idle.
    // delay < 0 means the external side never answers.
    task automatic run_access(input logic [15:0] addr, input logic [1:0] sel, input logic wr,
                              input logic [3:0] strb, input logic [31:0] wd,
                              input logic [1:0] exp_valid, input logic [7:0] exp_addr,
                              input int delay, input logic [1:0] noise,
                              input logic [31:0] rdata, input logic [1:0] st);
        int vc;
        req_q.push_back({exp_valid, wr, ~wr, exp_addr, strb, wd});
        if (delay < 0) rsp_q.push_back({32'h0, 2'b10});
        else           rsp_q.push_back({rdata, st});
        i_valid = 1'b1; i_select = sel; i_write = wr; i_read = ~wr;
        i_address = addr; i_strobe = strb; i_write_data = wd;
        @(posedge clk); #1;
        clear_inputs();
        check("req_issue", 64'(o_valid), 64'(exp_valid));
        if (delay >= 0) begin
            for (int c = 0; c < delay; c++) begin
                i_ready = noise;
                @(posedge clk); #1;
                check("req_hold", 64'(o_valid), 64'(exp_valid));
                check("no_early_rsp", 64'(o_ready), 64'(0));
            end
            drive_ready(exp_valid, rdata, st);
            @(posedge clk); #1;
            i_ready = 2'b00; i_read_data = '0; i_status = '0;
        end else begin
            vc = 1;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (o_valid != 2'b00) vc++;
                else break;
            end
            check("timeout_len", 64'(vc), 64'(TIMEOUT));
        end
        check("rsp_latency", 64'(o_ready), 64'(1));
        check("req_drop", 64'(o_valid), 64'(0));
        @(posedge clk); #1;
        check("rsp_pulse", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t_prev;
        int t_now;
        int found;
        rst = 1'b1;
        clear_inputs();
        i_ready = 2'b00; i_read_data = '0; i_status = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({o_valid, o_write, o_read, o_address, o_strobe, o_write_data}), 64'(0));
        check("reset_rsp", 64'({o_ready, o_read_data, o_status}), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Write into window 0, ready in the second request cycle.
        run_access(16'h0044, 2'b01, 1'b1, 4'hF, 32'hCAFE_0001, 2'b01, 8'h04, 1, 2'b00, 32'h0, 2'b00);
        // Read from window 1.
        run_access(16'h0108, 2'b10, 1'b0, 4'hF, 32'h0, 2'b10, 8'h08, 0, 2'b00, 32'h1234_5678, 2'b00);
        // Both selects set: channel 0 wins and channel 1 ready is ignored.
        run_access(16'h0050, 2'b11, 1'b1, 4'h3, 32'h0000_BEEF, 2'b01, 8'h10, 3, 2'b10, 32'h5555_0003, 2'b01);
        // Address below window 0 base wraps: 0x0020 - 0x0040 = 0xFFE0.
        run_access(16'h0020, 2'b01, 1'b0, 4'hF, 32'h0, 2'b01, 8'hE0, 0, 2'b00, 32'hA5A5_5A5A, 2'b10);
        // Address below window 1 base wraps: 0x00FF - 0x0100 = 0xFFFF.
        run_access(16'h00FF, 2'b10, 1'b1, 4'h8, 32'h8000_0001, 2'b10, 8'hFF, 2, 2'b01, 32'h0, 2'b11);

        // Valid with no select is not accepted.
        i_valid = 1'b1; i_select = 2'b00; i_write = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("no_select_idle", 64'(o_valid), 64'(0));
        end
        clear_inputs();

        // Reset during REQUEST, with i_valid held across the reset.
        req_q.push_back({2'b01, 1'b1, 1'b0, 8'h08, 4'hF, 32'h1111_2222});
        i_valid = 1'b1; i_select = 2'b01; i_write = 1'b1; i_read = 1'b0;
        i_address = 16'h0048; i_strobe = 4'hF; i_write_data = 32'h1111_2222;
        @(posedge clk); #1;
        check("rst_pre", 64'(o_valid), 64'(2'b01));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_clear", 64'({o_valid, o_write, o_read, o_address, o_strobe, o_write_data}), 64'(0));
        check("rst_no_rsp", 64'(o_ready), 64'(0));
        req_q.push_back({2'b01, 1'b1, 1'b0, 8'h08, 4'hF, 32'h1111_2222});
        rst = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        check("rst_reaccept", 64'(o_valid), 64'(2'b01));
        rsp_q.push_back({32'h0000_0000, 2'b00});
        drive_ready(2'b01, 32'h0, 2'b00);
        @(posedge clk); #1;
        i_ready = 2'b00; i_read_data = '0; i_status = '0;
        check("rst_rsp", 64'(o_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;

        // i_valid held high: one access per 4-cycle period, no re-issue in DONE.
        i_valid = 1'b1; i_select = 2'b10; i_write = 1'b0; i_read = 1'b1;
        i_address = 16'h0110; i_strobe = 4'hF; i_write_data = 32'h0;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            req_q.push_back({2'b10, 1'b0, 1'b1, 8'h10, 4'hF, 32'h0});
            rsp_q.push_back({32'h0000_1000 + 32'(k), 2'b00});
            found = 0;
            for (int c = 0; c < 10 && found == 0; c++) begin
                @(posedge clk); #1;
                if (o_valid != 2'b00) found = 1;
            end
            check("held_issue", 64'(found), 64'(1));
            t_now = cyc;
            if (k > 0) check("held_period", 64'(t_now - t_prev), 64'(4));
            t_prev = t_now;
            if (k == 2) clear_inputs();
            drive_ready(2'b10, 32'h0000_1000 + 32'(k), 2'b00);
            @(posedge clk); #1;
            i_ready = 2'b00; i_read_data = '0; i_status = '0;
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("held_no_extra", 64'(o_valid), 64'(0));
        end

`ifdef RGGEN_BUS_EXPORTER_TIMEOUT_EN
        // No ready: request held TIMEOUT cycles, then SLVERR with zero data.
        run_access(16'h0060, 2'b01, 1'b0, 4'hF, 32'h0, 2'b01, 8'h20, -1, 2'b00, 32'h0, 2'b00);
        // Ready on the limit cycle: the real response wins.
        run_access(16'h0104, 2'b10, 1'b0, 4'hF, 32'h0, 2'b10, 8'h04, TIMEOUT - 1, 2'b00, 32'h7777_8888, 2'b00);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("req_q_drained", 64'(req_q.size()), 64'(0));
        check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
